// File: rtl/i2s_rx_deser.sv
// I2S receive deserialiser: brings the codec's BCLK/LRC/ADC data into the MCLK
// domain, frames left-justified slots, and presents complete stereo pairs
// through a one-entry valid/ready output register.
// Optional feature: define I2S_RX_OVF_COUNT_EN to add the 8-bit saturating
// ovf_count output that counts dropped pairs.
module i2s_rx_deser #(
  parameter int SAMPLE_WIDTH = 24,
  parameter int SLOT_WIDTH   = 32,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                    MCLK,
  input  logic                    RESET,
  input  logic                    AUD_BCLK,
  input  logic                    AUD_LRC,
  input  logic                    AUD_ADC_DATA,
  output logic [SAMPLE_WIDTH-1:0] left_sample,
  output logic [SAMPLE_WIDTH-1:0] right_sample,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    overflow
`ifdef I2S_RX_OVF_COUNT_EN
  ,
  output logic [7:0]              ovf_count
`endif
);

  localparam int CNT_W = (SLOT_WIDTH > 1) ? $clog2(SLOT_WIDTH) : 1;
  localparam logic [CNT_W-1:0] SLOT_LAST   = CNT_W'(SLOT_WIDTH - 1);
  localparam logic [CNT_W-1:0] SAMPLE_LAST = CNT_W'(SAMPLE_WIDTH - 1);

  localparam logic [1:0] ST_WAIT_SYNC = 2'd0;
  localparam logic [1:0] ST_LEFT      = 2'd1;
  localparam logic [1:0] ST_RIGHT     = 2'd2;

  // Synchroniser chain: each stage carries {bclk, lrc, data}
  logic [SYNC_STAGES-1:0][2:0] sync_reg;
  logic                        bclk_prev_reg;
  logic                        bclk_s;
  logic                        lrc_s;
  logic                        data_s;
  logic                        bit_strobe;

  // Capture state
  logic [1:0]              state_reg;
  logic [1:0]              state_next;
  logic                    lrc_prev_reg;
  logic [CNT_W-1:0]        bit_cnt_reg;
  logic [CNT_W-1:0]        bit_idx_next;
  logic [SAMPLE_WIDTH-1:0] shift_reg;
  logic [SAMPLE_WIDTH-1:0] word_next;
  logic [SAMPLE_WIDTH-1:0] left_word_reg;
  logic                    left_valid_reg;
  logic                    lrc_change;
  logic                    advance;
  logic                    word_done;

  // Completed pair handed to the output stage
  logic                    pair_done_reg;
  logic [SAMPLE_WIDTH-1:0] pair_left_reg;
  logic [SAMPLE_WIDTH-1:0] pair_right_reg;
  logic                    handshake;

`ifdef I2S_RX_OVF_COUNT_EN
  logic [7:0] ovf_cnt_reg;
  assign ovf_count = ovf_cnt_reg;
`endif

  assign bclk_s     = sync_reg[SYNC_STAGES-1][2];
  assign lrc_s      = sync_reg[SYNC_STAGES-1][1];
  assign data_s     = sync_reg[SYNC_STAGES-1][0];
  assign bit_strobe = bclk_s & ~bclk_prev_reg;
  assign handshake  = out_valid & out_ready;

  // Resynchronise the codec inputs and keep one extra BCLK flop for edge detection
  always_ff @(posedge MCLK or posedge RESET) begin
    if (RESET) begin
      sync_reg      <= '0;
      bclk_prev_reg <= 1'b0;
    end else begin
      sync_reg[0] <= {AUD_BCLK, AUD_LRC, AUD_ADC_DATA};
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_reg[i] <= sync_reg[i-1];
      end
      bclk_prev_reg <= bclk_s;
    end
  end

  // Slot framing: bit index, word assembly and slot state for this strobe
  always_comb begin
    lrc_change   = lrc_s ^ lrc_prev_reg;
    // A saturated counter must not re-trigger capture of the same index
    advance      = lrc_change || (bit_cnt_reg != SLOT_LAST);
    bit_idx_next = bit_cnt_reg;
    if (lrc_change) begin
      bit_idx_next = '0;
    end else if (bit_cnt_reg != SLOT_LAST) begin
      bit_idx_next = bit_cnt_reg + CNT_W'(1);
    end
    word_next = {shift_reg[SAMPLE_WIDTH-2:0], data_s};
    word_done = advance && (bit_idx_next == SAMPLE_LAST);
    state_next = state_reg;
    case (state_reg)
      ST_WAIT_SYNC: if (lrc_change && !lrc_s) state_next = ST_LEFT;
      ST_LEFT:      if (lrc_change &&  lrc_s) state_next = ST_RIGHT;
      ST_RIGHT:     if (lrc_change && !lrc_s) state_next = ST_LEFT;
      default:      state_next = ST_WAIT_SYNC;
    endcase
  end

  // Capture bits on each strobe; latch the left word, then flag a full pair
  always_ff @(posedge MCLK or posedge RESET) begin
    if (RESET) begin
      state_reg      <= ST_WAIT_SYNC;
      lrc_prev_reg   <= 1'b0;
      bit_cnt_reg    <= '0;
      shift_reg      <= '0;
      left_word_reg  <= '0;
      left_valid_reg <= 1'b0;
      pair_done_reg  <= 1'b0;
      pair_left_reg  <= '0;
      pair_right_reg <= '0;
    end else begin
      pair_done_reg <= 1'b0;
      if (bit_strobe) begin
        lrc_prev_reg <= lrc_s;
        bit_cnt_reg  <= bit_idx_next;
        state_reg    <= state_next;
        if (advance && (bit_idx_next <= SAMPLE_LAST)) begin
          shift_reg <= word_next;
        end
        // A new left slot starts a new frame; any stale left word is dropped
        if (lrc_change && (state_next == ST_LEFT)) begin
          left_valid_reg <= 1'b0;
        end
        if (word_done && (state_next == ST_LEFT)) begin
          left_word_reg  <= word_next;
          left_valid_reg <= 1'b1;
        end
        if (word_done && (state_next == ST_RIGHT) && left_valid_reg) begin
          pair_done_reg  <= 1'b1;
          pair_left_reg  <= left_word_reg;
          pair_right_reg <= word_next;
          left_valid_reg <= 1'b0;
        end
      end
    end
  end

  // One-entry output register: load when empty or draining, else drop and flag
  always_ff @(posedge MCLK or posedge RESET) begin
    if (RESET) begin
      left_sample  <= '0;
      right_sample <= '0;
      out_valid    <= 1'b0;
      overflow     <= 1'b0;
`ifdef I2S_RX_OVF_COUNT_EN
      ovf_cnt_reg  <= 8'd0;
`endif
    end else begin
      if (pair_done_reg) begin
        if (!out_valid || handshake) begin
          left_sample  <= pair_left_reg;
          right_sample <= pair_right_reg;
          out_valid    <= 1'b1;
        end else begin
          overflow <= 1'b1;
`ifdef I2S_RX_OVF_COUNT_EN
          if (ovf_cnt_reg != 8'hFF) begin
            ovf_cnt_reg <= ovf_cnt_reg + 8'd1;
          end
`endif
        end
      end else if (handshake) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_i2s_rx_deser.sv
// Bench for i2s_rx_deser: drives I2S frames MCLK-aligned, pushes the expected
// pairs into a queue, and a negedge monitor pops and compares on every accept.
`timescale 1ns/1ps
module tb_i2s_rx_deser;

  localparam int SW   = 24;
  localparam int SLW  = 32;
  localparam int SYNC = 2;
  // BCLK half-period in MCLK cycles
  localparam int HALF = 4;

  logic          MCLK = 1'b0;
  logic          RESET;
  logic          AUD_BCLK;
  logic          AUD_LRC;
  logic          AUD_ADC_DATA;
  logic          out_ready;
  logic [SW-1:0] left_sample;
  logic [SW-1:0] right_sample;
  logic          out_valid;
  logic          overflow;
`ifdef I2S_RX_OVF_COUNT_EN
  logic [7:0]    ovf_count;
`endif

  int checks   = 0;
  int failures = 0;
  int pair_no  = 0;
  logic [2*SW-1:0] exp_q[$];
  logic [2*SW-1:0] mon_exp;

  always #10 MCLK = ~MCLK;

  i2s_rx_deser #(
    .SAMPLE_WIDTH(SW),
    .SLOT_WIDTH  (SLW),
    .SYNC_STAGES (SYNC)
  ) dut (
    .MCLK        (MCLK),
    .RESET       (RESET),
    .AUD_BCLK    (AUD_BCLK),
    .AUD_LRC     (AUD_LRC),
    .AUD_ADC_DATA(AUD_ADC_DATA),
    .left_sample (left_sample),
    .right_sample(right_sample),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .overflow    (overflow)
`ifdef I2S_RX_OVF_COUNT_EN
    ,
    .ovf_count   (ovf_count)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge MCLK);
    if (n > 0) #1;
  endtask

  // One BCLK period; optionally pulse out_ready for the cycle the pair lands
  task automatic drive_bit(input logic lrc, input logic d, input bit pulse);
    AUD_BCLK     = 1'b0;
    AUD_LRC      = lrc;
    AUD_ADC_DATA = d;
    wait_cyc(HALF);
    AUD_BCLK = 1'b1;
    if (pulse) begin
      wait_cyc(SYNC + 1);
      out_ready = 1'b1;
      wait_cyc(1);
      out_ready = 1'b0;
      wait_cyc(HALF - SYNC - 2);
    end else begin
      wait_cyc(HALF);
    end
  endtask

  task automatic send_slot(input logic lrc, input logic [SW-1:0] val, input int len, input bit pulse);
    logic d;
    for (int i = 0; i < len; i++) begin
      d = (i < SW) ? val[SW-1-i] : i[0];
      drive_bit(lrc, d, pulse && (i == SW - 1));
    end
  endtask

  task automatic send_frame(input logic [SW-1:0] l, input logic [SW-1:0] r,
                            input int llen, input bit pulse);
    send_slot(1'b0, l, llen, 1'b0);
    send_slot(1'b1, r, SLW, pulse);
  endtask

  // Monitor: every accepted pair must match the head of the queue
  always @(negedge MCLK) begin
    if (!RESET && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_pair actual=%h_%h required=none", left_sample, right_sample);
      end else begin
        mon_exp = exp_q.pop_front();
        check("pair_left",  {8'h00, left_sample},  {8'h00, mon_exp[2*SW-1:SW]});
        check("pair_right", {8'h00, right_sample}, {8'h00, mon_exp[SW-1:0]});
        $display("pair %0d left=%h right=%h", pair_no, left_sample, right_sample);
        pair_no++;
      end
    end
  end

  initial begin
    logic [SW-1:0] v;
    int budget;
    RESET        = 1'b1;
    AUD_BCLK     = 1'b0;
    AUD_LRC      = 1'b0;
    AUD_ADC_DATA = 1'b0;
    out_ready    = 1'b1;
    wait_cyc(5);
    check("rst_left",     {8'h00, left_sample},  32'h0);
    check("rst_right",    {8'h00, right_sample}, 32'h0);
    check("rst_valid",    {31'h0, out_valid},    32'h0);
    check("rst_overflow", {31'h0, overflow},     32'h0);
`ifdef I2S_RX_OVF_COUNT_EN
    check("rst_ovf_count", {24'h0, ovf_count}, 32'h0);
`endif
    RESET = 1'b0;
    wait_cyc(3);

    // Lone right slot: only the following LRC fall may start framing
    send_slot(1'b1, 24'hFFFFFF, SLW, 1'b0);

    // Steady frames of 000001
    for (int k = 0; k < 3; k++) begin
      exp_q.push_back({24'h000001, 24'h000001});
      send_frame(24'h000001, 24'h000001, SLW, 1'b0);
    end

    // Sign boundary crossing
    for (int k = 0; k < 3; k++) begin
      v = 24'h7FFFFE + 24'(k);
      exp_q.push_back({v, v});
      send_frame(v, v, SLW, 1'b0);
    end

    // Short left slot drops its frame; next frame is intact
    send_frame(24'h0F0F0F, 24'h0F0F0F, 10, 1'b0);
    exp_q.push_back({24'h123456, 24'hABCDEF});
    send_frame(24'h123456, 24'hABCDEF, SLW, 1'b0);

    // Accept coinciding with a completion: reload, stay valid, no overflow
    out_ready = 1'b0;
    exp_q.push_back({24'h5A5A5A, 24'hA5A5A5});
    send_frame(24'h5A5A5A, 24'hA5A5A5, SLW, 1'b0);
    exp_q.push_back({24'hC00001, 24'h3FFFFF});
    send_frame(24'hC00001, 24'h3FFFFF, SLW, 1'b1);
    wait_cyc(2);
    check("coincide_valid",    {31'h0, out_valid}, 32'h1);
    check("coincide_overflow", {31'h0, overflow},  32'h0);
    out_ready = 1'b1;
    wait_cyc(4);
    check("drained_valid", {31'h0, out_valid}, 32'h0);

    // Back-pressure for three frames: first pair held, two dropped
    out_ready = 1'b0;
    exp_q.push_back({24'h111111, 24'h222222});
    send_frame(24'h111111, 24'h222222, SLW, 1'b0);
    send_frame(24'h333333, 24'h444444, SLW, 1'b0);
    send_frame(24'h555555, 24'h666666, SLW, 1'b0);
    wait_cyc(2);
    check("bp_valid",    {31'h0, out_valid}, 32'h1);
    check("bp_overflow", {31'h0, overflow},  32'h1);
`ifdef I2S_RX_OVF_COUNT_EN
    check("bp_ovf_count", {24'h0, ovf_count}, 32'd2);
`endif
    out_ready = 1'b1;
    wait_cyc(4);
    check("sticky_overflow", {31'h0, overflow},  32'h1);
    check("bp_drained",      {31'h0, out_valid}, 32'h0);

    // Reset mid right slot, then resynchronise
    send_slot(1'b0, 24'h777777, SLW, 1'b0);
    send_slot(1'b1, 24'h888888, 10, 1'b0);
    RESET = 1'b1;
    wait_cyc(3);
    check("midrst_valid",    {31'h0, out_valid}, 32'h0);
    check("midrst_overflow", {31'h0, overflow},  32'h0);
    check("midrst_left",     {8'h00, left_sample}, 32'h0);
`ifdef I2S_RX_OVF_COUNT_EN
    check("midrst_ovf_count", {24'h0, ovf_count}, 32'h0);
`endif
    RESET = 1'b0;
    send_slot(1'b1, 24'h999999, SLW - 10, 1'b0);
    exp_q.push_back({24'h13579B, 24'h2468AC});
    send_frame(24'h13579B, 24'h2468AC, SLW, 1'b0);

    budget = 0;
    while (exp_q.size() != 0 && budget < 200) begin
      wait_cyc(1);
      budget++;
    end
    check("queue_drained", 32'(exp_q.size()), 32'h0);
    wait_cyc(5);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
